// File: rtl/dice_reader_pkg.sv
// Shared constants for the dice block and its reader: FSM state encoding
// and the seven-segment patterns shown for each face.
package dice_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PULSE     = 3'd1,
    S_WAIT_LOW  = 3'd2,
    S_WAIT_HIGH = 3'd3,
    S_SETTLE    = 3'd4,
    S_REPORT    = 3'd5
  } state_t;

  // Segment patterns, a=bit0 ... g=bit6, active-high.
  localparam logic [6:0] SEG_ONE   = 7'b0000110;
  localparam logic [6:0] SEG_TWO   = 7'b1011011;
  localparam logic [6:0] SEG_THREE = 7'b1001111;
  localparam logic [6:0] SEG_FOUR  = 7'b1100110;
  localparam logic [6:0] SEG_FIVE  = 7'b1101101;
  localparam logic [6:0] SEG_SIX   = 7'b1111100;

  // Display bus value assumed after reset: blank segments, dp set (settled).
  localparam logic [7:0] SEG_IN_RESET = 8'h80;

  localparam int FACES = 6;

endpackage

// File: rtl/seg_decode.sv
// Maps a settled display byte to a die face 1..6. Only a byte with the
// settled flag (bit 7) set and one of the six known patterns is valid.
module seg_decode
  import dice_reader_pkg::*;
(
  input  logic [7:0] SEG,
  output logic [2:0] FACE,
  output logic       VALID
);

  // Pattern lookup; anything unrecognised decodes to face 0, invalid.
  always_comb begin
    FACE  = 3'd0;
    VALID = 1'b0;
    case (SEG[6:0])
      SEG_ONE:   FACE = 3'd1;
      SEG_TWO:   FACE = 3'd2;
      SEG_THREE: FACE = 3'd3;
      SEG_FOUR:  FACE = 3'd4;
      SEG_FIVE:  FACE = 3'd5;
      SEG_SIX:   FACE = 3'd6;
      default:   FACE = 3'd0;
    endcase
    VALID = SEG[7] && (FACE != 3'd0);
    if (!VALID) FACE = 3'd0;
  end

endmodule

// File: rtl/dice_reader.sv
// Dice reader: requests a roll, follows the display through rolling and
// settling, decodes the settled face and keeps a per-face histogram.
//
// Handshake: START is a level request, accepted only while IDLE (never
// queued). ROLL, RESULT_VALID and ERROR are single-cycle strobes with no
// back-pressure; RESULT and the counters are registered and change on the
// same edge that raises RESULT_VALID/ERROR.
module dice_reader
  import dice_reader_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int COUNT_W        = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               CLEAR,
  input  logic [7:0]         SEG_IN,
  output logic               ROLL,
  output logic               BUSY,
  output logic [2:0]         RESULT,
  output logic               RESULT_VALID,
  output logic               ERROR,
  input  logic [2:0]         RD_FACE,
  output logic [COUNT_W-1:0] RD_COUNT,
  output logic [COUNT_W-1:0] TOTAL,
  output logic [7:0]         ERR_COUNT,
  output state_t             STATE_DBG
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]       SETTLE_N = 9'(SETTLE_CYCLES);

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         seg_q;
  logic [7:0]         ref_q;
  logic [7:0]         settle_cnt;
  logic [TMR_W-1:0]   timer;
  logic               dp;
  logic               in_wait;
  logic               enter_wait;
  logic               tmr_expired;
  logic               wait_timeout;
  logic               seg_same;
  logic               settle_done;
  logic [2:0]         dec_face;
  logic               dec_valid;
  logic               rpt_ok;
  logic               err_evt;
  logic [COUNT_W-1:0] hist_q [FACES];
  logic [COUNT_W-1:0] total_q;
  logic [7:0]         err_cnt_q;
  logic [2:0]         result_q;
  logic               rv_q;
  logic               err_q;

  assign dp          = seg_q[7];
  assign in_wait     = (state == S_WAIT_LOW) || (state == S_WAIT_HIGH);
  // The timer holds the number of completed cycles in the current wait
  // state, so it expires at the end of the TIMEOUT_CYCLES-th cycle.
  assign tmr_expired = (timer == TMR_LAST);
  assign wait_timeout = tmr_expired &&
                        (((state == S_WAIT_LOW) && dp) ||
                         ((state == S_WAIT_HIGH) && !dp));
  assign enter_wait  = ((state_nxt == S_WAIT_LOW) || (state_nxt == S_WAIT_HIGH)) &&
                       (state_nxt != state);
  // The sample taken on entry to SETTLE counts as the first identical one.
  assign seg_same    = (seg_q == ref_q);
  assign settle_done = seg_same && (({1'b0, settle_cnt} + 9'd1) >= SETTLE_N);
  assign rpt_ok      = (state == S_REPORT) && dec_valid;
  assign err_evt     = ((state == S_REPORT) && !dec_valid) || wait_timeout;

  // Decode the pattern that survived the settle window.
  seg_decode u_seg_decode (
    .SEG   (ref_q),
    .FACE  (dec_face),
    .VALID (dec_valid)
  );

  // Single register stage on the display bus; all decisions use seg_q.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) seg_q <= SEG_IN_RESET;
    else     seg_q <= SEG_IN;
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (START) state_nxt = S_PULSE;
      S_PULSE:     state_nxt = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (!dp)              state_nxt = S_WAIT_HIGH;
        else if (tmr_expired) state_nxt = S_IDLE;
      end
      S_WAIT_HIGH: begin
        if (dp)               state_nxt = S_SETTLE;
        else if (tmr_expired) state_nxt = S_IDLE;
      end
      S_SETTLE: begin
        if (!dp)              state_nxt = S_WAIT_HIGH;
        else if (settle_done) state_nxt = S_REPORT;
      end
      S_REPORT:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    ROLL      = (state == S_PULSE);
    BUSY      = (state != S_IDLE);
    STATE_DBG = state;
  end

  // Shared wait timer, restarted on entry to either wait state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                           timer <= '0;
    else if (enter_wait)               timer <= '0;
    else if (in_wait && !tmr_expired)  timer <= timer + TMR_W'(1);
  end

  // Settle tracker: reference byte and its run length.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ref_q      <= SEG_IN_RESET;
      settle_cnt <= '0;
    end else if ((state == S_WAIT_HIGH) && (state_nxt == S_SETTLE)) begin
      ref_q      <= seg_q;
      settle_cnt <= 8'd1;
    end else if (state == S_SETTLE) begin
      if (!seg_same) begin
        ref_q      <= seg_q;
        settle_cnt <= 8'd1;
      end else if (settle_cnt != 8'hFF) begin
        settle_cnt <= settle_cnt + 8'd1;
      end
    end
  end

  // Result register and completion strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      result_q <= '0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rv_q  <= rpt_ok;
      err_q <= err_evt;
      if (rpt_ok)       result_q <= dec_face;
      else if (err_evt) result_q <= '0;
    end
  end

  // Saturating histogram, total and error counters; CLEAR wins over counting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FACES; i++) hist_q[i] <= '0;
      total_q   <= '0;
      err_cnt_q <= '0;
    end else if (CLEAR) begin
      for (int i = 0; i < FACES; i++) hist_q[i] <= '0;
      total_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      for (int i = 0; i < FACES; i++) begin
        if (rpt_ok && (dec_face == 3'(i + 1)) && (hist_q[i] != '1))
          hist_q[i] <= hist_q[i] + COUNT_W'(1);
      end
      if (rpt_ok && (total_q != '1))    total_q   <= total_q + COUNT_W'(1);
      if (err_evt && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  // Histogram read port; faces 0 and 7 read as zero.
  always_comb begin
    RD_COUNT = '0;
    for (int i = 0; i < FACES; i++) begin
      if (RD_FACE == 3'(i + 1)) RD_COUNT = hist_q[i];
    end
  end

  assign RESULT       = result_q;
  assign RESULT_VALID = rv_q;
  assign ERROR        = err_q;
  assign TOTAL        = total_q;
  assign ERR_COUNT    = err_cnt_q;

endmodule

// File: doc/dice_reader.md
DICE_READER -- requirements
Module: dice_reader

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning consecutive identical samples required before a roll result is accepted (valid range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning maximum cycles spent in either wait state before aborting.
REQ-003 SHALL have parameter COUNT_W, default 16, meaning width of the histogram and total counters.
REQ-004 SHALL have one clock; reset is asynchronous and active-high (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed): CLK  in  1  rising-edge clock.
REQ-005 SHALL have RST  in  1  asynchronous active-high reset.
REQ-006 SHALL have START  in  1  level; request one roll when idle.
REQ-007 SHALL have CLEAR  in  1  level; zero all histogram, total and error counters.
REQ-008 SHALL have SEG_IN  in  8  display bus from the dice block: [6:0] segments, active-high, a=bit0 ... g=bit6; [7] dp, 1 = settled, 0 = rolling.
REQ-009 SHALL have ROLL  out  1  one-cycle roll request to the dice block.
REQ-010 SHALL have BUSY  out  1  high whenever the FSM is not IDLE.
REQ-011 SHALL have RESULT  out  3  last decoded face 1..6; 0 = none or invalid.
REQ-012 SHALL have RESULT_VALID  out  1  one-cycle pulse when RESULT is updated with a valid face.
REQ-013 SHALL have ERROR  out  1  one-cycle pulse on invalid pattern or timeout.
REQ-014 SHALL have RD_FACE  in  3  histogram read select, 1..6.
REQ-015 SHALL have RD_COUNT  out  COUNT_W  combinational read of the count for RD_FACE; 0 for RD_FACE of 0 or 7.
REQ-016 SHALL have TOTAL  out  COUNT_W  number of valid results since reset or CLEAR.
REQ-017 SHALL have ERR_COUNT  out  8  number of ERROR pulses since reset or CLEAR.

Function
REQ-018 SHALL register SEG_IN once and use only the registered copy for all decisions.
REQ-019 SHALL decode the registered segments as 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5, 1111100=6; every other pattern is invalid.
REQ-020 SHALL implement states IDLE, PULSE, WAIT_LOW, WAIT_HIGH, SETTLE and REPORT.
REQ-021 SHALL move IDLE->PULSE on START=1; START outside IDLE is ignored and not queued.
REQ-022 SHALL drive ROLL=1 only in PULSE, so START sampled at edge t gives ROLL high for exactly the cycle after edge t; PULSE->WAIT_LOW unconditionally.
REQ-023 SHALL move WAIT_LOW->WAIT_HIGH on registered dp=0, and WAIT_HIGH->SETTLE on registered dp=1.
REQ-024 SHALL count wait cycles in a shared timer cleared on entry to each wait state; on reaching TIMEOUT_CYCLES it pulses ERROR, sets RESULT=0 and returns to IDLE.
REQ-025 SHALL in SETTLE count cycles with the registered byte unchanged; any change restarts the count; dp=0 returns to WAIT_HIGH; reaching SETTLE_CYCLES moves to REPORT.
REQ-026 SHALL in REPORT, for a valid face: load RESULT, pulse RESULT_VALID, increment that face count and TOTAL; for an invalid pattern: RESULT=0, pulse ERROR. REPORT->IDLE always.
REQ-027 SHALL saturate every counter at its all-ones value, with no wrap-around.
REQ-028 SHALL make CLEAR take precedence over an increment in the same cycle, so counters read 0 afterwards while RESULT/RESULT_VALID still update; CLEAR does not affect the FSM.
REQ-029 SHALL allow a new START on the first cycle after return to IDLE (back-to-back rolls).

Reset
REQ-030 SHALL on RST put the FSM in IDLE and set ROLL=0, BUSY=0, RESULT=0, RESULT_VALID=0, ERROR=0, all counters 0, the SEG_IN register to 8'h80 and the timers to 0.
REQ-031 SHALL abandon an in-progress roll immediately on RST mid-operation, with no ERROR pulse and no counter change.

Structure
REQ-032 SHALL place the state encoding and the six segment patterns in the shared dice package, so the dice block and this reader use identical constants.
REQ-033 SHALL place the pattern-to-face decode in one sub-module, seg_decode (8-bit in, 3-bit face, valid flag).

Verification
REQ-034 SHALL verify: START=1 for 1 cycle -> ROLL high exactly 1 cycle, BUSY high until REPORT completes.
REQ-035 SHALL verify: dp low 10 cycles then SEG_IN=8'hED held 4 cycles -> RESULT=5, one RESULT_VALID pulse, RD_FACE=5 gives RD_COUNT=1, TOTAL=1.
REQ-036 SHALL verify: SEG_IN=8'h86 then 8'hDB during settle, then 8'hDB stable -> count restarts, RESULT=2, no result of 1.
REQ-037 SHALL verify: settled SEG_IN=8'hFF -> ERROR pulse, RESULT=0, ERR_COUNT=1, TOTAL unchanged.
REQ-038 SHALL verify: dp held high with TIMEOUT_CYCLES=20 -> ERROR on cycle 20 of WAIT_LOW, FSM in IDLE; RST asserted in SETTLE -> all outputs at reset values.
REQ-039 SHALL verify: COUNT_W=2 with face 3 rolled 5 times, and CLEAR coincident with a REPORT -> RD_COUNT saturates at 3, then all counters read 0.
